// File: rtl/mem_access_ctrl.sv
// Multicycle data-memory access sequencer: loads, word stores, sub-word read-modify-write stores.
// Latency: loads and sb/sh done at T+MEM_LAT+2, sw at T+2, rejected requests at T+1; one request at a time, req ignored while busy.
module mem_access_ctrl #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [2:0]  sh_sel,
    output logic        mdr_wr
);

    localparam logic [2:0] OP_SB = 3'b000;
    localparam logic [2:0] OP_SW = 3'b001;
    localparam logic [2:0] OP_SH = 3'b010;
    localparam logic [2:0] OP_LB = 3'b011;
    localparam logic [2:0] OP_LW = 3'b100;
    localparam logic [2:0] OP_LH = 3'b101;
    localparam logic [2:0] SEL_ZERO = 3'b111;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, DONE} state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [31:0]      addr_q;
    logic [CNT_W-1:0] cnt;
    logic             reject;
    logic             is_load;

    // Only consumed by the IDLE transition, so inputs never reach an output combinationally.
    always_comb begin
        reject = 1'b0;
        if (op[2:1] == 2'b11)
            reject = 1'b1;
        else if ((op == OP_SH || op == OP_LH) && addr[0])
            reject = 1'b1;
        else if ((op == OP_SW || op == OP_LW) && addr[1:0] != 2'b00)
            reject = 1'b1;
    end

    assign is_load  = (op_q == OP_LB) || (op_q == OP_LW) || (op_q == OP_LH);
    assign mem_addr = addr_q;

    // Outputs are loaded together with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= 3'b000;
            addr_q <= 32'd0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            mdr_wr <= 1'b0;
            sh_sel <= SEL_ZERO;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            mem_wr <= 1'b0;
            mdr_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_q   <= op;
                        addr_q <= addr;
                        busy   <= 1'b1;
                        sh_sel <= op;
                        if (reject) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (op == OP_SW) begin
                            state  <= WRITE;
                            mem_wr <= 1'b1;
                        end else begin
                            state  <= READ;
                            cnt    <= '0;
                            mem_rd <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (cnt < CNT_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        mem_rd <= 1'b0;
                        if (is_load) begin
                            state  <= LATCH;
                            mdr_wr <= 1'b1;
                        end else begin
                            state  <= WRITE;
                            mem_wr <= 1'b1;
                        end
                    end
                end
                LATCH, WRITE: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    sh_sel <= SEL_ZERO;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    mem_rd <= 1'b0;
                    sh_sel <= SEL_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: per-cycle comparison against an output-schedule model plus directed latency/strobe-count checks.
module tb_mem_access_ctrl;

    localparam int MEM_LAT = 2;

    localparam logic [2:0] SB = 3'b000, SW = 3'b001, SH = 3'b010,
                           LB = 3'b011, LW = 3'b100, LH = 3'b101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] addr = 32'd0;
    logic        busy, done, err, mem_rd, mem_wr, mdr_wr;
    logic [31:0] mem_addr;
    logic [2:0]  sh_sel;

    mem_access_ctrl #(.MEM_LAT(MEM_LAT), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr),
        .busy(busy), .done(done), .err(err), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .sh_sel(sh_sel), .mdr_wr(mdr_wr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic       rd;
        logic       wr;
        logic       mdr;
        logic [2:0] sel;
    } out_t;

    localparam out_t IDLE_O = 9'b000000111;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int wr_total = 0;
    int done_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic out_t mk(input bit b, input bit d, input bit e, input bit r,
                                input bit w, input bit m, input logic [2:0] s);
        return {b, d, e, r, w, m, s};
    endfunction

    // Model: an accepted request expands into the list of per-cycle output values it must produce.
    out_t        sched[$];
    out_t        exp_o = IDLE_O;
    logic [31:0] exp_a = 32'd0;

    task automatic build(input logic [2:0] o, input logic [31:0] a);
        int size;
        bit bad;
        bit load;
        case (o)
            SB, LB:  size = 1;
            SH, LH:  size = 2;
            default: size = 4;
        endcase
        bad  = (o > 3'd5) || ((a % size) != 0);
        load = (o == LB) || (o == LW) || (o == LH);
        if (bad) begin
            sched.push_back(mk(1, 1, 1, 0, 0, 0, o));
        end else if (o == SW) begin
            sched.push_back(mk(1, 0, 0, 0, 1, 0, o));
            sched.push_back(mk(1, 1, 0, 0, 0, 0, o));
        end else begin
            for (int i = 0; i < MEM_LAT; i++) sched.push_back(mk(1, 0, 0, 1, 0, 0, o));
            if (load) sched.push_back(mk(1, 0, 0, 0, 0, 1, o));
            else      sched.push_back(mk(1, 0, 0, 0, 1, 0, o));
            sched.push_back(mk(1, 1, 0, 0, 0, 0, o));
        end
        // The cycle after done is always idle, whatever req does.
        sched.push_back(IDLE_O);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            sched.delete();
            exp_o = IDLE_O;
            exp_a = 32'd0;
        end else begin
            if (sched.size() == 0 && req) begin
                build(op, addr);
                exp_a = addr;
            end
            if (sched.size() != 0) exp_o = sched.pop_front();
            else                   exp_o = IDLE_O;
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("outputs", 32'({busy, done, err, mem_rd, mem_wr, mdr_wr, sh_sel}), 32'(exp_o));
            check("mem_addr", mem_addr, exp_a);
            if (mem_wr === 1'b1) wr_total++;
            if (done === 1'b1) done_total++;
        end
    end

    // Drives one request and holds req through the done cycle and the edge after it.
    task automatic run_req(input string name, input logic [2:0] o, input logic [31:0] a,
                           input int lat, input int nrd, input int nwr, input int nmdr, input bit e);
        int  c = 0;
        int  rd_c = 0;
        int  wr_c = 0;
        int  mdr_c = 0;
        bit  acc = 1'b0;
        bit  seen_done = 1'b0;
        bit  err_seen = 1'b0;
        @(negedge clk);
        req = 1'b1; op = o; addr = a;
        for (int k = 0; k < 20 && !seen_done; k++) begin
            @(posedge clk); #1;
            if (!acc && busy) acc = 1'b1;
            if (acc) c++;
            if (mem_rd) rd_c++;
            if (mem_wr) wr_c++;
            if (mdr_wr) mdr_c++;
            if (done) begin
                seen_done = 1'b1;
                err_seen = err;
                check({name, "_addr_at_done"}, mem_addr, a);
            end
        end
        if (!seen_done) begin
            errors++; checks++;
            $display("FAIL %s_timeout: no done within 20 cycles", name);
        end
        check({name, "_latency"}, c, lat);
        check({name, "_rd_cycles"}, rd_c, nrd);
        check({name, "_wr_cycles"}, wr_c, nwr);
        check({name, "_mdr_cycles"}, mdr_c, nmdr);
        check({name, "_err"}, 32'(err_seen), 32'(e));
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check({name, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_strobes", 32'({mem_rd, mem_wr, mdr_wr, done, err}), 32'd0);
            check("rst_sh_sel", 32'(sh_sel), 32'h7);
            check("rst_mem_addr", mem_addr, 32'd0);
        end

        run_req("lw10", LW, 32'h10, 4, 2, 0, 1, 1'b0);
        run_req("sb23", SB, 32'h23, 4, 2, 1, 0, 1'b0);
        run_req("sw08", SW, 32'h08, 2, 0, 1, 0, 1'b0);
        run_req("lh05", LH, 32'h05, 1, 0, 0, 0, 1'b1);
        run_req("lw06", LW, 32'h06, 1, 0, 0, 0, 1'b1);
        run_req("op6",  3'b110, 32'h00, 1, 0, 0, 0, 1'b1);

        // sh aborted by reset during its second read cycle.
        @(negedge clk);
        req = 1'b1; op = SH; addr = 32'h04;
        @(negedge clk);
        check("sh_read1", 32'(mem_rd), 32'd1);
        req = 1'b0;
        @(negedge clk);
        check("sh_read2_sel", 32'(sh_sel), 32'(SH));
        req = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_strobes", 32'({mem_rd, mem_wr, done, err}), 32'd0);
        check("abort_addr", mem_addr, 32'd0);

        run_req("lb07", LB, 32'h07, 4, 2, 0, 1, 1'b0);

        repeat (3) @(negedge clk);
        check("total_writes", 32'(wr_total), 32'd2);
        check("total_dones", 32'(done_total), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
